// File: rtl/row_mac_sequencer.sv
// -----------------------------------------------------------------------------
// row_mac_sequencer
//
// Per-row sequencer between main_controller and the multiply-accumulate
// datapath. When begin_mult is seen in IDLE, the row index on res_add is
// latched. For that row the block:
//   1. clears the accumulator (CLEAR, one cycle),
//   2. issues one matrix/vector read per column (ISSUE, NUM_COLS cycles),
//   3. waits for the last read to come back (DRAIN, RD_LAT cycles),
//   4. writes the result at the latched row (WRITE, one cycle),
//   5. pulses done_row (DONE, one cycle).
// An out-of-range row index goes straight to DONE, where row_err pulses
// together with done_row. No reads or writes are issued for that row.
//
// mac_en is the tail of a valid shift register of depth RD_LAT, so a read
// issued in cycle t is accumulated in cycle t+RD_LAT.
//
// Optional build macro: ROW_MAC_SEQUENCER_STALL_EN
//   Adds input mem_ready. While mem_ready=0 in ISSUE, the column is held and
//   a bubble enters the valid pipeline. When the macro is undefined, the
//   block behaves as if mem_ready=1.
//
// Ports:
//   clk        in   system clock, rising edge
//   n_reset    in   asynchronous active-low reset
//   begin_mult in   level request to process row res_add
//   res_add    in   [3:0] row index, sampled only at row start
//   mem_ready  in   (STALL_EN build only) memory can accept a read
//   done_row   out  one-cycle pulse when the row is complete
//   row_err    out  one-cycle pulse with done_row for an out-of-range row
//   mat_add    out  [MAT_AW-1:0] matrix read address, row*NUM_COLS+col
//   vec_add    out  [3:0] vector read address, col
//   mac_clear  out  accumulator clear
//   mac_en     out  accumulate the current memory read data
//   res_wen    out  result buffer write strobe
//   res_wadd   out  [3:0] result buffer write address (latched row)
// -----------------------------------------------------------------------------
module row_mac_sequencer #(
    parameter int NUM_COLS = 10,
    parameter int NUM_ROWS = 10,
    parameter int RD_LAT   = 1,
    parameter int MAT_AW   = 7
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              begin_mult,
    input  logic [3:0]        res_add,
`ifdef ROW_MAC_SEQUENCER_STALL_EN
    input  logic              mem_ready,
`endif
    output logic              done_row,
    output logic              row_err,
    output logic [MAT_AW-1:0] mat_add,
    output logic [3:0]        vec_add,
    output logic              mac_clear,
    output logic              mac_en,
    output logic              res_wen,
    output logic [3:0]        res_wadd
);

    localparam int                DW         = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [DW-1:0]     DRAIN_LAST = DW'(RD_LAT - 1);
    localparam logic [3:0]        COL_LAST   = 4'(NUM_COLS - 1);
    localparam logic [4:0]        ROW_LIMIT  = 5'(NUM_ROWS);
    localparam logic [MAT_AW-1:0] COLS_M     = MAT_AW'(NUM_COLS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [3:0]          r_row;
    logic [3:0]          r_col;
    logic [DW-1:0]       r_drain_cnt;
    logic [MAT_AW-1:0]   r_mat_add;
    logic [3:0]          r_vec_add;
    logic                r_mac_clear;
    logic                r_res_wen;
    logic [3:0]          r_res_wadd;
    logic                r_done_row;
    logic                r_row_err;
    logic [RD_LAT-1:0]   r_vld;

    logic                w_ready;
    logic                w_push;
    logic [MAT_AW-1:0]   w_row_base;

`ifdef ROW_MAC_SEQUENCER_STALL_EN
    assign w_ready = mem_ready;
`else
    assign w_ready = 1'b1;
`endif

    // A read is issued only in ISSUE cycles where memory accepts it.
    assign w_push     = (r_state == S_ISSUE) && w_ready;
    assign w_row_base = MAT_AW'(r_row) * COLS_M;

    // -------------------------------------------------------------------------
    // Control FSM. The strobes default to 0 every cycle and are set on the
    // transition into the state that owns them, so each one is a registered
    // single-cycle pulse that lines up with its state.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state     <= S_IDLE;
            r_row       <= 4'd0;
            r_col       <= 4'd0;
            r_drain_cnt <= '0;
            r_mat_add   <= '0;
            r_vec_add   <= 4'd0;
            r_mac_clear <= 1'b0;
            r_res_wen   <= 1'b0;
            r_res_wadd  <= 4'd0;
            r_done_row  <= 1'b0;
            r_row_err   <= 1'b0;
        end else begin
            r_mac_clear <= 1'b0;
            r_res_wen   <= 1'b0;
            r_done_row  <= 1'b0;
            r_row_err   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (begin_mult) begin
                        r_row <= res_add;
                        if ({1'b0, res_add} >= ROW_LIMIT) begin
                            r_state    <= S_DONE;
                            r_done_row <= 1'b1;
                            r_row_err  <= 1'b1;
                        end else begin
                            r_state     <= S_CLEAR;
                            r_mac_clear <= 1'b1;
                        end
                    end
                end

                S_CLEAR: begin
                    // Preload the first column's addresses so they are
                    // present throughout the first ISSUE cycle.
                    r_col     <= 4'd0;
                    r_mat_add <= w_row_base;
                    r_vec_add <= 4'd0;
                    r_state   <= S_ISSUE;
                end

                S_ISSUE: begin
                    if (w_ready) begin
                        if (r_col == COL_LAST) begin
                            // Column counter stops at the last column; the
                            // address outputs return to 0 outside ISSUE.
                            r_mat_add   <= '0;
                            r_vec_add   <= 4'd0;
                            r_drain_cnt <= '0;
                            r_state     <= S_DRAIN;
                        end else begin
                            r_col     <= r_col + 4'd1;
                            r_mat_add <= r_mat_add + 1'b1;
                            r_vec_add <= r_vec_add + 4'd1;
                        end
                    end
                end

                S_DRAIN: begin
                    // The last read was issued in the final ISSUE cycle, so
                    // it retires exactly RD_LAT cycles later, in the last
                    // DRAIN cycle.
                    if (r_drain_cnt == DRAIN_LAST) begin
                        r_state    <= S_WRITE;
                        r_res_wen  <= 1'b1;
                        r_res_wadd <= r_row;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end

                S_WRITE: begin
                    r_res_wadd <= 4'd0;
                    r_done_row <= 1'b1;
                    r_state    <= S_DONE;
                end

                S_DONE: begin
                    r_col   <= 4'd0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Read-valid pipeline. A 1 is shifted in for every issued read and a 0
    // for every other cycle, including stall cycles. The tail bit is mac_en.
    // -------------------------------------------------------------------------
    generate
        if (RD_LAT == 1) begin : g_vld_single
            always_ff @(posedge clk or negedge n_reset) begin
                if (!n_reset) begin
                    r_vld <= '0;
                end else begin
                    r_vld <= w_push;
                end
            end
        end else begin : g_vld_multi
            always_ff @(posedge clk or negedge n_reset) begin
                if (!n_reset) begin
                    r_vld <= '0;
                end else begin
                    r_vld <= {r_vld[RD_LAT-2:0], w_push};
                end
            end
        end
    endgenerate

    assign done_row  = r_done_row;
    assign row_err   = r_row_err;
    assign mat_add   = r_mat_add;
    assign vec_add   = r_vec_add;
    assign mac_clear = r_mac_clear;
    assign mac_en    = r_vld[RD_LAT-1];
    assign res_wen   = r_res_wen;
    assign res_wadd  = r_res_wadd;

endmodule

// File: tb/tb_row_mac_sequencer.sv
// -----------------------------------------------------------------------------
// tb_row_mac_sequencer
//
// The reference model works at the level of a row schedule. When a row starts
// in cycle k, it plans the whole row:
//   - mac_clear in cycle k+1,
//   - one read per ready cycle from k+2 on,
//   - mac_en RD_LAT cycles after each read,
//   - res_wen and done_row after the last read.
// These expectations are written into per-cycle arrays. Every cycle the
// outputs are compared with the arrays. Directed scenarios also check
// end-to-end latency, pulse counts and write addresses against constants.
// -----------------------------------------------------------------------------
module tb_row_mac_sequencer;

    localparam int NC   = 10;
    localparam int NR   = 10;
    localparam int AW   = 7;
`ifdef ROW_MAC_SEQUENCER_STALL_EN
    localparam int RL   = 2;
`else
    localparam int RL   = 1;
`endif
    localparam int MAXC = 4096;

    logic          clk        = 1'b0;
    logic          n_reset    = 1'b0;
    logic          begin_mult = 1'b0;
    logic [3:0]    res_add    = 4'd0;
`ifdef ROW_MAC_SEQUENCER_STALL_EN
    logic          mem_ready  = 1'b1;
`endif
    logic          done_row;
    logic          row_err;
    logic [AW-1:0] mat_add;
    logic [3:0]    vec_add;
    logic          mac_clear;
    logic          mac_en;
    logic          res_wen;
    logic [3:0]    res_wadd;

    row_mac_sequencer #(
        .NUM_COLS (NC),
        .NUM_ROWS (NR),
        .RD_LAT   (RL),
        .MAT_AW   (AW)
    ) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .begin_mult (begin_mult),
        .res_add    (res_add),
`ifdef ROW_MAC_SEQUENCER_STALL_EN
        .mem_ready  (mem_ready),
`endif
        .done_row   (done_row),
        .row_err    (row_err),
        .mat_add    (mat_add),
        .vec_add    (vec_add),
        .mac_clear  (mac_clear),
        .mac_en     (mac_en),
        .res_wen    (res_wen),
        .res_wadd   (res_wadd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected per-cycle outputs; e_am masks address checks on stall cycles.
    bit e_clr  [MAXC];
    bit e_en   [MAXC];
    bit e_wen  [MAXC];
    bit e_done [MAXC];
    bit e_err  [MAXC];
    bit e_am   [MAXC];
    int e_wadd [MAXC];
    int e_mat  [MAXC];
    int e_vec  [MAXC];
    bit rdy_arr[MAXC];

    int m_idle_from = 1 << 30;
    int m_row       = 0;
    bit m_err       = 1'b0;
    int s_k, s_t, s_c, s_last;

    int n_chk  = 0;
    int n_pass = 0;

    int en_cnt = 0, wen_cnt = 0, last_wadd = -1, last_done_cyc = -1;
    int last_en = -1, last_err = -1;
    int done_q[$];
    int clear_q[$];
    bit done_prev = 1'b0;
    int start_cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic model_clear(input int from);
        for (int i = from; i < MAXC; i++) begin
            e_clr[i] = 0; e_en[i] = 0; e_wen[i] = 0; e_done[i] = 0; e_err[i] = 0;
            e_am[i] = 1; e_wadd[i] = 0; e_mat[i] = 0; e_vec[i] = 0;
        end
    endtask

    // Compare, monitor, then let the model react to this cycle's inputs.
    always @(negedge clk) begin
        if (cyc < MAXC) begin
            chk("mac_clear", 32'(mac_clear), 32'(e_clr[cyc]));
            chk("mac_en",    32'(mac_en),    32'(e_en[cyc]));
            chk("res_wen",   32'(res_wen),   32'(e_wen[cyc]));
            chk("res_wadd",  32'(res_wadd),  e_wadd[cyc]);
            chk("done_row",  32'(done_row),  32'(e_done[cyc]));
            chk("row_err",   32'(row_err),   32'(e_err[cyc]));
            if (e_am[cyc]) begin
                chk("mat_add", 32'(mat_add), e_mat[cyc]);
                chk("vec_add", 32'(vec_add), e_vec[cyc]);
            end
        end

        if (mac_en) en_cnt++;
        if (res_wen) begin
            wen_cnt++;
            last_wadd = int'(res_wadd);
        end
        if (mac_clear) clear_q.push_back(cyc);
        if (done_row) begin
            done_q.push_back(cyc);
            last_done_cyc = cyc;
            last_en = en_cnt;
            last_err = int'(row_err);
            chk("row_mac_en_count", en_cnt, m_err ? 0 : NC);
            chk("row_wen_count", wen_cnt, m_err ? 0 : 1);
            $display("row %0d done at cycle %0d err=%0d mac_en=%0d wen=%0d",
                     m_row, cyc, row_err, en_cnt, wen_cnt);
            en_cnt  = 0;
            wen_cnt = 0;
        end
        done_prev = done_row;

        if (n_reset && cyc >= m_idle_from && begin_mult && cyc < MAXC - 64) begin
            s_k   = cyc;
            m_row = int'(res_add);
            m_err = (m_row >= NR);
            if (m_err) begin
                e_done[s_k+1] = 1;
                e_err[s_k+1]  = 1;
                m_idle_from   = s_k + 2;
            end else begin
                e_clr[s_k+1] = 1;
                s_t = s_k + 2;
                s_c = 0;
                while (s_c < NC && s_t < MAXC - 16) begin
                    if (rdy_arr[s_t]) begin
                        e_mat[s_t]     = m_row * NC + s_c;
                        e_vec[s_t]     = s_c;
                        e_en[s_t + RL] = 1;
                        s_c++;
                    end else begin
                        e_am[s_t] = 0;
                    end
                    s_t++;
                end
                s_last = s_t - 1;
                e_wen[s_last + RL + 1]  = 1;
                e_wadd[s_last + RL + 1] = m_row;
                e_done[s_last + RL + 2] = 1;
                m_idle_from = s_last + RL + 3;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
`ifdef ROW_MAC_SEQUENCER_STALL_EN
        mem_ready = rdy_arr[(cyc < MAXC) ? cyc : 0];
`endif
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (cyc < m_idle_from && n < budget) begin
            step();
            n++;
        end
        chk("idle_reached", 32'(cyc >= m_idle_from), 32'd1);
    endtask

    task automatic clear_log();
        done_q.delete();
        clear_q.delete();
        last_wadd = -1;
        last_done_cyc = -1;
        last_en = -1;
        last_err = -1;
    endtask

    task automatic start_row(input logic [3:0] row);
        step();
        begin_mult = 1'b1;
        res_add    = row;
        start_cyc  = cyc;
    endtask

    initial begin
        for (int i = 0; i < MAXC; i++) rdy_arr[i] = 1;
        model_clear(0);

        // Reset state.
        repeat (3) step();
        chk("reset_outputs",
            32'({done_row, row_err, mat_add, vec_add, mac_clear, mac_en, res_wen, res_wadd}), 32'd0);
        step();
        #2;
        n_reset = 1'b1;
        m_idle_from = cyc;
        repeat (2) step();

        // Row 3: full directed sequence.
        clear_log();
        start_row(4'd3);
        step();
        begin_mult = 1'b0;
        wait_idle(100);
        chk("row3_latency", last_done_cyc - start_cyc, NC + RL + 3);
        chk("row3_clear_at_1", (clear_q.size() > 0) ? clear_q[0] - start_cyc : -1, 1);
        chk("row3_wadd", last_wadd, 3);

        // Back-to-back rows 0 then 1 with begin_mult held.
        clear_log();
        start_row(4'd0);
        begin
            int nd = 0;
            int n = 0;
            while (nd < 2 && n < 200) begin
                step();
                n++;
                if (done_prev) begin
                    nd++;
                    if (nd == 2) begin_mult = 1'b0;
                    else res_add = 4'd1;
                end
            end
        end
        wait_idle(100);
        chk("b2b_done_count", done_q.size(), 2);
        chk("b2b_clear_gap",
            (clear_q.size() > 1 && done_q.size() > 0) ? clear_q[1] - done_q[0] : -1, 2);
        chk("b2b_last_wadd", last_wadd, 1);

        // Out-of-range row 12.
        clear_log();
        start_row(4'd12);
        step();
        begin_mult = 1'b0;
        wait_idle(50);
        chk("oor_latency", last_done_cyc - start_cyc, 1);
        chk("oor_err", last_err, 1);
        chk("oor_no_clear", clear_q.size(), 0);
        chk("oor_no_wen", last_wadd, -1);
        repeat (3) step();

        // Reset at the 6th ISSUE cycle of row 4, then row 2 after release.
        clear_log();
        start_row(4'd4);
        step();
        begin_mult = 1'b0;
        repeat (6) step();
        chk("pre_reset_vec", 32'(vec_add), 32'd5);
        chk("pre_reset_mat", 32'(mat_add), 32'd45);
        #1;
        n_reset = 1'b0;
        model_clear(cyc);
        m_idle_from = 1 << 30;
        en_cnt  = 0;
        wen_cnt = 0;
        #1;
        chk("reset_async_outputs",
            32'({done_row, row_err, mat_add, vec_add, mac_clear, mac_en, res_wen, res_wadd}), 32'd0);
        repeat (2) step();
        step();
        #2;
        clear_log();
        n_reset    = 1'b1;
        begin_mult = 1'b1;
        res_add    = 4'd2;
        m_idle_from = cyc;
        start_cyc  = cyc;
        step();
        begin_mult = 1'b0;
        wait_idle(100);
        chk("after_reset_done_count", done_q.size(), 1);
        chk("after_reset_wadd", last_wadd, 2);
        chk("after_reset_latency", last_done_cyc - start_cyc, NC + RL + 3);

        // begin_mult dropped and res_add changed mid-row 5.
        clear_log();
        start_row(4'd5);
        repeat (5) step();
        begin_mult = 1'b0;
        res_add    = 4'd7;
        wait_idle(100);
        repeat (20) step();
        chk("drop_wadd", last_wadd, 5);
        chk("drop_done_count", done_q.size(), 1);

`ifdef ROW_MAC_SEQUENCER_STALL_EN
        // Three stall cycles at column 4.
        clear_log();
        start_row(4'd6);
        for (int i = 0; i < 3; i++) rdy_arr[start_cyc + 6 + i] = 0;
        step();
        begin_mult = 1'b0;
        wait_idle(100);
        chk("stall_latency", last_done_cyc - start_cyc, NC + RL + 3 + 3);
        chk("stall_mac_en_total", last_en, 10);
        chk("stall_wadd", last_wadd, 6);
        for (int i = cyc + 1; i < MAXC; i++) rdy_arr[i] = ($urandom_range(0, 3) != 0);
`endif

        // Randomized requests, row indices and mid-row input changes.
        for (int i = 0; i < 900; i++) begin
            step();
            begin_mult = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) res_add = 4'($urandom_range(0, 15));
        end
        begin_mult = 1'b0;
        wait_idle(300);
        repeat (5) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/row_mac_sequencer.md
Name: row_mac_sequencer

Overview:
- Per-row sequencer sitting between main_controller and the multiply-accumulate datapath.
- Each row is started by main_controller's begin_mult/res_add. For that row the block issues the matrix and vector read addresses column by column, aligns MAC enables with the fixed memory read latency, writes the accumulated result to the result buffer at res_add, and pulses done_row.
- main_controller advances res_add on that done_row pulse.

Parameters:
- NUM_COLS, 10: columns per row; one MAC operation per column.
- NUM_ROWS, 10: valid row indices are 0..NUM_ROWS-1.
- RD_LAT, 1: matrix/vector memory read latency in cycles; must be >= 1.
- MAT_AW, 7: matrix address width; must satisfy 2^MAT_AW >= NUM_ROWS*NUM_COLS.

Ports:
- clk, in, 1: system clock; rising-edge active.
- n_reset, in, 1: asynchronous active-low reset.
- begin_mult, in, 1: level request from main_controller to process row res_add.
- res_add, in, 4: row index; sampled only at row start.
- done_row, out, 1: one-cycle pulse when the row is complete.
- row_err, out, 1: one-cycle pulse, coincident with done_row, when the sampled row index was out of range.
- mat_add, out, MAT_AW: matrix read address, equal to row*NUM_COLS + col.
- vec_add, out, 4: vector read address, equal to col.
- mac_clear, out, 1: clears the accumulator.
- mac_en, out, 1: accumulate the current memory read data.
- res_wen, out, 1: result buffer write strobe.
- res_wadd, out, 4: result buffer write address, equal to the latched row.

Behaviour:
- Single clock domain. Reset is asynchronous, active-low.
- Reset state: IDLE; col=0; row latch=0; pipeline cleared; every output 0.
- No combinational path from any input to any output. Outputs are registers or decodes of registered state.
- IDLE: if begin_mult=1, latch row<=res_add.
  - Row >= NUM_ROWS: go to DONE without issuing reads or writes, and assert row_err there.
  - Otherwise go to CLEAR.
- CLEAR (1 cycle): mac_clear=1; col<=0; then go to ISSUE.
- ISSUE (NUM_COLS cycles):
  - Drive mat_add and vec_add for the current col, and push a 1 into a valid shift register of depth RD_LAT.
  - col increments each cycle. After col==NUM_COLS-1, go to DRAIN.
- mac_en: the valid bit RD_LAT cycles after issue. An address issued in cycle t yields mac_en=1 in cycle t+RD_LAT.
- DRAIN (RD_LAT cycles): no new issue; wait until the valid pipeline is empty (counter). Then go to WRITE.
- WRITE (1 cycle): res_wen=1; res_wadd=latched row; then go to DONE.
- DONE (1 cycle): done_row=1; then go to IDLE.
- Timing contract with main_controller: main_controller updates res_add on the edge after done_row. The IDLE cycle that follows samples the new row, and a new row starts if begin_mult is still 1.
- Latency: from the begin_mult-sampling edge to the done_row cycle is 1+NUM_COLS+RD_LAT+1 cycles in CLEAR/ISSUE/DRAIN/WRITE, then DONE. With defaults, done_row is asserted 14 cycles after the sampling edge.
- begin_mult dropping mid-row: ignored; the row always completes.
- res_add changing mid-row: ignored, because the row is latched at start.
- Address outputs outside ISSUE: held at 0.
- Reset mid-row: immediate return to IDLE with all outputs 0; the partial accumulation is discarded and no res_wen is issued.
- Width rules:
  - mat_add is computed at MAT_AW bits with no overflow for legal rows.
  - The col counter is 4 bits and stops at NUM_COLS-1; it does not wrap.

Optional Feature:
- Macro: ROW_MAC_SEQUENCER_STALL_EN.
- When defined, an extra input port mem_ready (in, 1) is added after res_add.
  - In ISSUE with mem_ready=0: no address is pushed, col holds, and a 0 enters the valid pipeline.
  - Reads already in flight still retire after RD_LAT.
  - DRAIN is entered only after all NUM_COLS columns have been issued.
- When undefined: no mem_ready port; behaviour is as if mem_ready=1.

Test Plan:
- Row 3, begin_mult=1, defaults:
  - mac_clear in cycle 1; mat_add 30..39 and vec_add 0..9 in cycles 2..11.
  - mac_en=1 in cycles 3..12.
  - res_wen=1 with res_wadd=3 in cycle 13; done_row=1 in cycle 14, single-cycle.
- Back-to-back rows 0 then 1, with begin_mult held and res_add advanced on done_row:
  - The second CLEAR follows 2 cycles after done_row, and mat_add starts at 10.
  - No duplicate write to address 0.
- res_add=12 (out of range): done_row and row_err both pulse 1 cycle after the start edge; no res_wen and no mac_en.
- n_reset driven low at the 6th ISSUE cycle:
  - All outputs go to 0 asynchronously and no res_wen follows.
  - After release with begin_mult=1 and res_add=2, the full row 2 sequence runs (mat_add 20..29).
- begin_mult dropped and res_add changed to 7 mid-row 5: the row completes with res_wadd=5, after which the block stays in IDLE.
- STALL_EN build, RD_LAT=2, mem_ready=0 for 3 cycles at col=4:
  - col holds at 4, with a 3-cycle gap in mac_en.
  - mac_en totals exactly 10 pulses, and done_row arrives 3 cycles later than in the unstalled case.
